// File: rtl/weight_load_sequencer.sv
// Weight load sequencer: streams ROWS*COLS weights into the PE weight buffer in
// raster order and keeps a table of faulty PE coordinates for the recompute units.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; row[0]/col[0] show fault slot 0
// S_LOAD | accepting stream weights, one buffer write per handshake
// S_DONE | one-cycle terminal state coincident with the final write
module weight_load_sequencer #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int NUM_RU    = 4,
  parameter int WORD_SIZE = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          w_valid,
  input  logic [WORD_SIZE-1:0]          w_data,
  output logic                          w_ready,
  input  logic                          fault_valid,
  input  logic [ROWS-1:0]               fault_row,
  input  logic [COLS-1:0]               fault_col,
  input  logic                          fault_clear,
  output logic                          we,
  output logic [WORD_SIZE-1:0]          weight,
  output logic [ROWS-1:0]               row [0:NUM_RU-1],
  output logic [COLS-1:0]               col [0:NUM_RU-1],
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_RU+1)-1:0]   ru_count,
  output logic                          overflow
);

  localparam int CW         = $clog2(NUM_RU+1);
  localparam int ROW_LAST_I = ROWS - 1;
  localparam int COL_LAST_I = COLS - 1;
  localparam int RU_FULL_I  = NUM_RU;
  localparam logic [ROWS-1:0] ROW_LAST = ROW_LAST_I[ROWS-1:0];
  localparam logic [COLS-1:0] COL_LAST = COL_LAST_I[COLS-1:0];
  localparam logic [CW-1:0]   RU_FULL  = RU_FULL_I[CW-1:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic            hs;
  logic            last_elem;
  logic [ROWS-1:0] nxt_row;
  logic [COLS-1:0] nxt_col;
  logic [ROWS-1:0] wr_row;
  logic [COLS-1:0] wr_col;
  logic [ROWS-1:0] slot_row [0:NUM_RU-1];
  logic [COLS-1:0] slot_col [0:NUM_RU-1];

  assign hs        = w_valid & w_ready;
  assign last_elem = (nxt_row == ROW_LAST) && (nxt_col == COL_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (hs && last_elem) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_LOAD: begin
        w_ready = 1'b1;
        busy    = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // nxt_* is the address the next handshake will use; wr_* is the address of
  // the element presented to the buffer this cycle (registered with we/weight).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nxt_row <= '0;
      nxt_col <= '0;
      wr_row  <= '0;
      wr_col  <= '0;
      we      <= 1'b0;
      weight  <= '0;
    end else begin
      we <= hs;
      if (state == S_IDLE && start) begin
        nxt_row <= '0;
        nxt_col <= '0;
        wr_row  <= '0;
        wr_col  <= '0;
      end else if (hs) begin
        weight <= w_data;
        wr_row <= nxt_row;
        wr_col <= nxt_col;
        if (nxt_col == COL_LAST) begin
          nxt_col <= '0;
          nxt_row <= last_elem ? '0 : nxt_row + 1'b1;
        end else begin
          nxt_col <= nxt_col + 1'b1;
        end
      end
    end
  end

  // Fault table fills in arrival order; clear wins over a same-cycle capture.
  always_ff @(posedge clk) begin
    if (!rst_n || fault_clear) begin
      for (int i = 0; i < NUM_RU; i++) begin
        slot_row[i] <= '0;
        slot_col[i] <= '0;
      end
      ru_count <= '0;
      overflow <= 1'b0;
    end else if (fault_valid) begin
      if (ru_count < RU_FULL) begin
        for (int i = 0; i < NUM_RU; i++) begin
          if (ru_count == CW'(i)) begin
            slot_row[i] <= fault_row;
            slot_col[i] <= fault_col;
          end
        end
        ru_count <= ru_count + 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_RU; r++) begin
      row[r] = slot_row[r];
      col[r] = slot_col[r];
    end
    if (busy) begin
      row[0] = wr_row;
      col[0] = wr_col;
    end
  end

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Directed bench for weight_load_sequencer (4x4 array, 4 recompute units, 16-bit weights).
module tb_weight_load_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        w_valid;
  logic [15:0] w_data;
  logic        w_ready;
  logic        fault_valid;
  logic [3:0]  fault_row;
  logic [3:0]  fault_col;
  logic        fault_clear;
  logic        we;
  logic [15:0] weight;
  logic [3:0]  row [0:3];
  logic [3:0]  col [0:3];
  logic        busy;
  logic        done;
  logic [2:0]  ru_count;
  logic        overflow;

  int nvec = 0;
  int nerr = 0;

  weight_load_sequencer #(
    .ROWS(4), .COLS(4), .NUM_RU(4), .WORD_SIZE(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .w_valid(w_valid), .w_data(w_data),
    .w_ready(w_ready), .fault_valid(fault_valid), .fault_row(fault_row),
    .fault_col(fault_col), .fault_clear(fault_clear), .we(we), .weight(weight),
    .row(row), .col(col), .busy(busy), .done(done), .ru_count(ru_count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] fr [0:4];
    logic [3:0] fc [0:4];
    logic [3:0] er [0:3];
    logic [3:0] ec [0:3];
    fr = '{4'd1, 4'd3, 4'd0, 4'd2, 4'd1};
    fc = '{4'd2, 4'd0, 4'd3, 4'd2, 4'd1};
    er = '{4'd1, 4'd3, 4'd0, 4'd2};
    ec = '{4'd2, 4'd0, 4'd3, 4'd2};

    rst_n = 1'b0; start = 1'b0; w_valid = 1'b0; w_data = '0;
    fault_valid = 1'b0; fault_row = '0; fault_col = '0; fault_clear = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_we", 32'(we), 0);
    chk("rst_weight", 32'(weight), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_ru", 32'(ru_count), 0);
    chk("rst_wready", 32'(w_ready), 0);
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("rst_row%0d", r), 32'(row[r]), 0);
      chk($sformatf("rst_col%0d", r), 32'(col[r]), 0);
    end

    // full 16-element load
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("s1_busy", 32'(busy), 1);
    chk("s1_wready", 32'(w_ready), 1);
    chk("s1_we0", 32'(we), 0);
    for (int k = 0; k < 16; k++) begin
      w_valid = 1'b1; w_data = 16'(k);
      @(negedge clk);
      chk($sformatf("s1_we_%0d", k), 32'(we), 1);
      chk($sformatf("s1_w_%0d", k), 32'(weight), k);
      chk($sformatf("s1_row_%0d", k), 32'(row[0]), k / 4);
      chk($sformatf("s1_col_%0d", k), 32'(col[0]), k % 4);
      chk($sformatf("s1_done_%0d", k), 32'(done), 32'(k == 15));
    end
    chk("s1_wready_done", 32'(w_ready), 0);
    w_valid = 1'b0;
    @(negedge clk);
    chk("s1_idle_busy", 32'(busy), 0);
    chk("s1_idle_done", 32'(done), 0);
    chk("s1_idle_we", 32'(we), 0);
    chk("s1_idle_hold", 32'(weight), 32'h000F);

    // stalled stream, start ignored while loading
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; w_valid = 1'b1; w_data = 16'h00A0;
    @(negedge clk);
    chk("s2_we_a", 32'(we), 1);
    chk("s2_w_a", 32'(weight), 32'h00A0);
    chk("s2_row_a", 32'(row[0]), 0);
    chk("s2_col_a", 32'(col[0]), 0);
    w_valid = 1'b0;
    @(negedge clk);
    chk("s2_we_gap", 32'(we), 0);
    chk("s2_w_gap", 32'(weight), 32'h00A0);
    chk("s2_busy_gap", 32'(busy), 1);
    w_valid = 1'b1; w_data = 16'h00A1; start = 1'b1;
    @(negedge clk);
    chk("s2_we_b", 32'(we), 1);
    chk("s2_w_b", 32'(weight), 32'h00A1);
    chk("s2_row_b", 32'(row[0]), 0);
    chk("s2_col_b", 32'(col[0]), 1);
    w_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("s2_we_end", 32'(we), 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("s2_rst_busy", 32'(busy), 0);

    // reset in the middle of a load, then a clean reload
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      w_valid = 1'b1; w_data = 16'(16'h0100 + k);
      @(negedge clk);
      chk($sformatf("s5_row_%0d", k), 32'(row[0]), k / 4);
      chk($sformatf("s5_col_%0d", k), 32'(col[0]), k % 4);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("s5_rst_we", 32'(we), 0);
    chk("s5_rst_busy", 32'(busy), 0);
    chk("s5_rst_wready", 32'(w_ready), 0);
    chk("s5_rst_weight", 32'(weight), 0);
    rst_n = 1'b1; w_valid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      w_valid = 1'b1; w_data = 16'(16'h0200 + k);
      @(negedge clk);
      chk($sformatf("s5b_we_%0d", k), 32'(we), 1);
      chk($sformatf("s5b_w_%0d", k), 32'(weight), 32'h0200 + k);
      chk($sformatf("s5b_row_%0d", k), 32'(row[0]), k / 4);
      chk($sformatf("s5b_col_%0d", k), 32'(col[0]), k % 4);
      chk($sformatf("s5b_done_%0d", k), 32'(done), 32'(k == 15));
    end
    w_valid = 1'b0;
    @(negedge clk);
    chk("s5b_idle_busy", 32'(busy), 0);

    // five faults into four slots
    for (int i = 0; i < 5; i++) begin
      fault_valid = 1'b1; fault_row = fr[i]; fault_col = fc[i];
      @(negedge clk);
      chk($sformatf("s3_ru_%0d", i), 32'(ru_count), (i < 4) ? i + 1 : 4);
      chk($sformatf("s3_ovf_%0d", i), 32'(overflow), 32'(i == 4));
    end
    fault_valid = 1'b0;
    @(negedge clk);
    chk("s3_ovf_sticky", 32'(overflow), 1);
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("s3_row%0d", r), 32'(row[r]), 32'(er[r]));
      chk($sformatf("s3_col%0d", r), 32'(col[r]), 32'(ec[r]));
    end

    // clear beats a simultaneous capture
    fault_clear = 1'b1; fault_valid = 1'b1; fault_row = 4'd3; fault_col = 4'd3;
    @(negedge clk);
    fault_clear = 1'b0; fault_valid = 1'b0;
    chk("s4_ru", 32'(ru_count), 0);
    chk("s4_ovf", 32'(overflow), 0);
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("s4_row%0d", r), 32'(row[r]), 0);
      chk($sformatf("s4_col%0d", r), 32'(col[r]), 0);
    end

    // fault captured during a load; row[0]/col[0] follow the write address
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      w_valid = 1'b1; w_data = 16'(16'h0300 + k);
      fault_valid = (k == 3); fault_row = 4'd2; fault_col = 4'd1;
      @(negedge clk);
      chk($sformatf("s6_row_%0d", k), 32'(row[0]), k / 4);
      chk($sformatf("s6_col_%0d", k), 32'(col[0]), k % 4);
    end
    chk("s6_done", 32'(done), 1);
    chk("s6_row1_empty", 32'(row[1]), 0);
    w_valid = 1'b0; fault_valid = 1'b0;
    @(negedge clk);
    chk("s6_idle_row0", 32'(row[0]), 2);
    chk("s6_idle_col0", 32'(col[0]), 1);
    chk("s6_idle_ru", 32'(ru_count), 1);
    chk("s6_idle_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
